decode_scoreboard: RTL and testbench



---
 rtl/decode_scoreboard.sv | 130 +++++++++++++
 tb/tb_decode_scoreboard.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/decode_scoreboard.sv
// -----------------------------------------------------------------------------
// decode_scoreboard
//
// Register-hazard scoreboard and issue controller for the decode stage.
// Each architectural register (except r0) has a small outstanding-write
// counter. An instruction is held in decode while any source it reads is
// still pending or its destination counter is already full. Counters go up
// when an instruction issues and come down when writeback retires a write.
//
// Ports:
//   sb_clk          clock, all state updates on the rising edge
//   sb_rst          synchronous active-high reset
//   sb_i_valid      decode holds a valid instruction
//   sb_i_addr_rs    source register rs
//   sb_i_addr_rt    source register rt
//   sb_i_use_rs     instruction reads rs
//   sb_i_use_rt     instruction reads rt
//   sb_i_reg_wr     instruction writes a register
//   sb_i_addr_wr    destination register (already muxed by reg_dst)
//   sb_i_wb_valid   writeback retires one register write this cycle
//   sb_i_wb_addr    register being retired
//   sb_o_stall      combinational, hold decode
//   sb_o_issue      combinational, sb_i_valid & ~sb_o_stall
//   sb_o_busy_rs    combinational, rs hazard term
//   sb_o_busy_rt    combinational, rt hazard term
//   sb_o_stall_cnt  registered, saturating count of stall cycles
//   sb_o_err        registered, sticky: writeback to a register with count 0
// -----------------------------------------------------------------------------
module decode_scoreboard #(
   parameter int NREG   = 32,
   parameter int AWIDTH = 5,
   parameter int CWIDTH = 2,
   parameter int SWIDTH = 16
) (
   input  logic              sb_clk,
   input  logic              sb_rst,
   input  logic              sb_i_valid,
   input  logic [AWIDTH-1:0] sb_i_addr_rs,
   input  logic [AWIDTH-1:0] sb_i_addr_rt,
   input  logic              sb_i_use_rs,
   input  logic              sb_i_use_rt,
   input  logic              sb_i_reg_wr,
   input  logic [AWIDTH-1:0] sb_i_addr_wr,
   input  logic              sb_i_wb_valid,
   input  logic [AWIDTH-1:0] sb_i_wb_addr,
   output logic              sb_o_stall,
   output logic              sb_o_issue,
   output logic              sb_o_busy_rs,
   output logic              sb_o_busy_rt,
   output logic [SWIDTH-1:0] sb_o_stall_cnt,
   output logic              sb_o_err
);

   // Entry 0 exists only so addresses index directly; it is held at zero.
   logic [CWIDTH-1:0] cnt_q [NREG];
   logic [CWIDTH-1:0] cnt_d [NREG];
   logic [SWIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic              err_q, err_d;

   logic [CWIDTH-1:0] cnt_rs, cnt_rt, cnt_wr, cnt_wb;
   logic              busy_rs, busy_rt, full_wr, stall, issue;

   // Counter lookups. Out-of-range addresses (only possible if NREG is not a
   // power of two) read as an idle register.
   always_comb begin
      cnt_rs = '0;
      cnt_rt = '0;
      cnt_wr = '0;
      cnt_wb = '0;
      if (32'(sb_i_addr_rs) < NREG) cnt_rs = cnt_q[sb_i_addr_rs];
      if (32'(sb_i_addr_rt) < NREG) cnt_rt = cnt_q[sb_i_addr_rt];
      if (32'(sb_i_addr_wr) < NREG) cnt_wr = cnt_q[sb_i_addr_wr];
      if (32'(sb_i_wb_addr) < NREG) cnt_wb = cnt_q[sb_i_wb_addr];
   end

   // Hazards use only the registered counters, so a writeback in the same
   // cycle never releases a stall early. Everything is gated by valid so an
   // empty decode slot reports no hazard at all.
   always_comb begin
      busy_rs = sb_i_valid & sb_i_use_rs & (sb_i_addr_rs != '0) & (cnt_rs != '0);
      busy_rt = sb_i_valid & sb_i_use_rt & (sb_i_addr_rt != '0) & (cnt_rt != '0);
      full_wr = sb_i_valid & sb_i_reg_wr & (sb_i_addr_wr != '0) & (cnt_wr == '1);
      stall   = busy_rs | busy_rt | full_wr;
      issue   = sb_i_valid & ~stall;
   end

   assign sb_o_busy_rs   = busy_rs;
   assign sb_o_busy_rt   = busy_rt;
   assign sb_o_stall     = stall;
   assign sb_o_issue     = issue;
   assign sb_o_stall_cnt = stall_cnt_q;
   assign sb_o_err       = err_q;

   // Per-register next-state. An issue and a retire on the same register
   // cancel out. Increment can never overflow because a full counter blocks
   // issue through full_wr.
   assign cnt_d[0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_cnt
         logic inc, dec;
         assign inc = issue & sb_i_reg_wr & (sb_i_addr_wr == AWIDTH'(gi));
         assign dec = sb_i_wb_valid & (sb_i_wb_addr == AWIDTH'(gi)) & (cnt_q[gi] != '0);
         assign cnt_d[gi] = (inc & ~dec) ? cnt_q[gi] + CWIDTH'(1) :
                            (dec & ~inc) ? cnt_q[gi] - CWIDTH'(1) :
                                           cnt_q[gi];
      end
   endgenerate

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + SWIDTH'(1);
      // Retiring a register that has nothing outstanding is a pipeline bug.
      err_d = err_q | (sb_i_wb_valid & (sb_i_wb_addr != '0) & (cnt_wb == '0));
   end

   always_ff @(posedge sb_clk) begin
      if (sb_rst) begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_decode_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_decode_scoreboard
//
// Directed, table-driven bench for decode_scoreboard. Each record holds one
// cycle of inputs plus the expected combinational outputs in that cycle and
// the expected registered outputs (state left by earlier edges). A short
// hand-written sequence at the end checks the same-cycle combinational path.
// -----------------------------------------------------------------------------
module tb_decode_scoreboard;

   localparam int AW = 5;
   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          valid;
   logic [AW-1:0] rs, rt, wr, wb_addr;
   logic          use_rs, use_rt, reg_wr, wb_valid;
   logic          stall, issue, busy_rs, busy_rt, err;
   logic [SW-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_scoreboard #(.NREG(32), .AWIDTH(AW), .CWIDTH(2), .SWIDTH(SW)) dut (
      .sb_clk        (clk),
      .sb_rst        (rst),
      .sb_i_valid    (valid),
      .sb_i_addr_rs  (rs),
      .sb_i_addr_rt  (rt),
      .sb_i_use_rs   (use_rs),
      .sb_i_use_rt   (use_rt),
      .sb_i_reg_wr   (reg_wr),
      .sb_i_addr_wr  (wr),
      .sb_i_wb_valid (wb_valid),
      .sb_i_wb_addr  (wb_addr),
      .sb_o_stall    (stall),
      .sb_o_issue    (issue),
      .sb_o_busy_rs  (busy_rs),
      .sb_o_busy_rt  (busy_rt),
      .sb_o_stall_cnt(stall_cnt),
      .sb_o_err      (err)
   );

   typedef struct {
      string         name;
      logic          rst;
      logic          valid;
      logic [AW-1:0] rs;
      logic          use_rs;
      logic [AW-1:0] rt;
      logic          use_rt;
      logic          reg_wr;
      logic [AW-1:0] wr;
      logic          wb_valid;
      logic [AW-1:0] wb_addr;
      logic          e_stall;
      logic          e_issue;
      logic          e_brs;
      logic          e_brt;
      int            e_scnt;
      logic          e_err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input string n, input logic r, input logic v,
                      input int a_rs, input logic u_rs, input int a_rt, input logic u_rt,
                      input logic w, input int a_wr, input logic wbv, input int a_wb,
                      input logic es, input logic ei, input logic ebs, input logic ebt,
                      input int ec, input logic ee);
      vec_t t;
      t.name = n; t.rst = r; t.valid = v;
      t.rs = AW'(a_rs); t.use_rs = u_rs; t.rt = AW'(a_rt); t.use_rt = u_rt;
      t.reg_wr = w; t.wr = AW'(a_wr); t.wb_valid = wbv; t.wb_addr = AW'(a_wb);
      t.e_stall = es; t.e_issue = ei; t.e_brs = ebs; t.e_brt = ebt;
      t.e_scnt = ec; t.e_err = ee;
      vecs.push_back(t);
   endtask

   task automatic chk1(input string n, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", n, act, exp);
      end
   endtask

   task automatic chk_cnt(input string n, input logic [SW-1:0] act, input int exp);
      checks++;
      if (act !== SW'(exp)) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", n, act, exp);
      end
   endtask

   initial begin
      //   name        rst v  rs u  rt u  wr a   wb a   stall iss brs brt scnt err
      add("rst_hold",   1, 0,  0,0, 0,0, 0,0,   1,5,   0,0,0,0, 0,0);
      add("post_rst",   0, 1,  5,1, 0,0, 0,0,   0,0,   0,1,0,0, 0,0);
      add("wb_r0",      0, 0,  0,0, 0,0, 0,0,   1,0,   0,0,0,0, 0,0);
      add("iss_w8",     0, 1,  0,0, 0,0, 1,8,   0,0,   0,1,0,0, 0,0);
      add("raw8_c1",    0, 1,  8,1, 0,0, 0,0,   0,0,   1,0,1,0, 0,0);
      add("raw8_c2",    0, 1,  8,1, 0,0, 0,0,   0,0,   1,0,1,0, 1,0);
      add("raw8_c3",    0, 1,  8,1, 0,0, 0,0,   0,0,   1,0,1,0, 2,0);
      add("raw8_wb",    0, 1,  8,1, 0,0, 0,0,   1,8,   1,0,1,0, 3,0);
      add("raw8_iss",   0, 1,  8,1, 0,0, 0,0,   0,0,   0,1,0,0, 4,0);
      add("iss_w0",     0, 1,  0,0, 0,0, 1,0,   0,0,   0,1,0,0, 4,0);
      add("rd_r0",      0, 1,  0,1, 0,1, 0,0,   0,0,   0,1,0,0, 4,0);
      add("wb_r0_b",    0, 0,  0,0, 0,0, 0,0,   1,0,   0,0,0,0, 4,0);
      add("iss_w7",     0, 1,  0,0, 0,0, 1,7,   0,0,   0,1,0,0, 4,0);
      add("raw7_rt",    0, 1,  7,0, 7,1, 0,0,   0,0,   1,0,0,1, 4,0);
      add("novalid7",   0, 0,  7,1, 7,1, 0,0,   1,7,   0,0,0,0, 5,0);
      add("rt7_iss",    0, 1,  0,0, 7,1, 0,0,   0,0,   0,1,0,0, 5,0);
      add("w3_a",       0, 1,  0,0, 0,0, 1,3,   0,0,   0,1,0,0, 5,0);
      add("w3_b",       0, 1,  0,0, 0,0, 1,3,   0,0,   0,1,0,0, 5,0);
      add("w3_c",       0, 1,  0,0, 0,0, 1,3,   0,0,   0,1,0,0, 5,0);
      add("w3_full_wb", 0, 1,  0,0, 0,0, 1,3,   1,3,   1,0,0,0, 5,0);
      add("w3_iss",     0, 1,  0,0, 0,0, 1,3,   0,0,   0,1,0,0, 6,0);
      add("w3_full2",   0, 1,  0,0, 0,0, 1,3,   0,0,   1,0,0,0, 6,0);
      add("wb3_a",      0, 0,  0,0, 0,0, 0,0,   1,3,   0,0,0,0, 7,0);
      add("wb3_b",      0, 0,  0,0, 0,0, 0,0,   1,3,   0,0,0,0, 7,0);
      add("rd3_wb",     0, 1,  3,1, 0,0, 0,0,   1,3,   1,0,1,0, 7,0);
      add("rd3_iss",    0, 1,  3,1, 0,0, 0,0,   0,0,   0,1,0,0, 8,0);
      add("iss_w4",     0, 1,  0,0, 0,0, 1,4,   0,0,   0,1,0,0, 8,0);
      add("w4_and_wb4", 0, 1,  0,0, 0,0, 1,4,   1,4,   0,1,0,0, 8,0);
      add("rd4_busy",   0, 1,  4,1, 0,0, 0,0,   0,0,   1,0,1,0, 8,0);
      add("wb4",        0, 0,  0,0, 0,0, 0,0,   1,4,   0,0,0,0, 9,0);
      add("rd4_iss",    0, 1,  4,1, 0,0, 0,0,   0,0,   0,1,0,0, 9,0);
      add("wb9_bad",    0, 0,  0,0, 0,0, 0,0,   1,9,   0,0,0,0, 9,0);
      add("err_w10",    0, 1,  0,0, 0,0, 1,10,  0,0,   0,1,0,0, 9,1);
      add("err_rd10",   0, 1, 10,1, 0,0, 0,0,   0,0,   1,0,1,0, 9,1);
      add("rst_rd10",   1, 1, 10,1, 0,0, 0,0,   0,0,   1,0,1,0, 10,1);
      add("after_rst",  0, 1, 10,1, 0,0, 0,0,   0,0,   0,1,0,0, 0,0);
      add("idle_end",   0, 0,  0,0, 0,0, 0,0,   0,0,   0,0,0,0, 0,0);

      // First reset cycle: state is still unknown, so nothing is checked yet.
      rst = 1'b1; valid = 1'b0; rs = '0; rt = '0; use_rs = 1'b0; use_rt = 1'b0;
      reg_wr = 1'b0; wr = '0; wb_valid = 1'b1; wb_addr = AW'(5);
      @(posedge clk);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; valid = vecs[i].valid;
         rs = vecs[i].rs; use_rs = vecs[i].use_rs;
         rt = vecs[i].rt; use_rt = vecs[i].use_rt;
         reg_wr = vecs[i].reg_wr; wr = vecs[i].wr;
         wb_valid = vecs[i].wb_valid; wb_addr = vecs[i].wb_addr;
         #1;
         $display("vec %0d %s: stall=%b issue=%b brs=%b brt=%b scnt=%0d err=%b",
                  i, vecs[i].name, stall, issue, busy_rs, busy_rt, stall_cnt, err);
         chk1({vecs[i].name, ".stall"}, stall, vecs[i].e_stall);
         chk1({vecs[i].name, ".issue"}, issue, vecs[i].e_issue);
         chk1({vecs[i].name, ".busy_rs"}, busy_rs, vecs[i].e_brs);
         chk1({vecs[i].name, ".busy_rt"}, busy_rt, vecs[i].e_brt);
         chk_cnt({vecs[i].name, ".stall_cnt"}, stall_cnt, vecs[i].e_scnt);
         chk1({vecs[i].name, ".err"}, err, vecs[i].e_err);
      end

      // Same-cycle combinational response: flipping use_rs mid-cycle must
      // change issue/stall without waiting for a clock edge.
      @(negedge clk);
      rst = 1'b0; valid = 1'b1; reg_wr = 1'b1; wr = AW'(12);
      use_rs = 1'b0; use_rt = 1'b0; wb_valid = 1'b0;
      #1;
      $display("seq iss_w12: issue=%b", issue);
      chk1("seq.iss_w12", issue, 1'b1);
      @(negedge clk);
      reg_wr = 1'b0; rs = AW'(12); use_rs = 1'b0;
      #1;
      $display("seq rd12_unused: issue=%b stall=%b", issue, stall);
      chk1("seq.rd12_unused.issue", issue, 1'b1);
      use_rs = 1'b1;
      #1;
      $display("seq rd12_used: issue=%b stall=%b", issue, stall);
      chk1("seq.rd12_used.stall", stall, 1'b1);
      chk1("seq.rd12_used.issue", issue, 1'b0);
      @(negedge clk);
      valid = 1'b0; use_rs = 1'b0; wb_valid = 1'b1; wb_addr = AW'(12);
      @(negedge clk);
      valid = 1'b1; use_rs = 1'b1; rs = AW'(12); wb_valid = 1'b0;
      #1;
      $display("seq rd12_after_wb: issue=%b scnt=%0d err=%b", issue, stall_cnt, err);
      chk1("seq.rd12_after_wb.issue", issue, 1'b1);
      chk_cnt("seq.rd12_after_wb.stall_cnt", stall_cnt, 1);
      chk1("seq.rd12_after_wb.err", err, 1'b0);
      @(negedge clk);
      valid = 1'b0; use_rs = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
